// File: rtl/seg_display_pkg.sv
// Shared types for the seven-segment display path.
//   mode_e      : conversion mode selected by mode_in (DECIMAL / HEXADECIMAL)
//   fmt_state_e : state encoding of the digit formatter FSM
//   digit_t     : one display nibble
package seg_display_pkg;

    typedef enum logic {
        DECIMAL     = 1'b0,
        HEXADECIMAL = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fmt_state_e;

    typedef logic [3:0] digit_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so that the following left shift carries into the next decimal digit.
//   bcd      in   digit_t   current BCD digit
//   adjusted out  digit_t   digit after the conditional +3
module bcd_digit_adjust
    import seg_display_pkg::*;
(
    input  digit_t bcd,
    output digit_t adjusted
);

    assign adjusted = (bcd >= 4'd5) ? bcd + 4'd3 : bcd;

endmodule

// File: rtl/seg_digit_formatter.sv
// Converts a binary value into display nibbles for the digit scan stage.
// HEXADECIMAL mode splits value_in directly into nibbles; DECIMAL mode runs an
// iterative double-dabble, one input bit per cycle.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined     : digit_en covers digit 0 up to the most-significant nonzero nibble
//   not defined : digit_en covers all BCD_DIGITS (decimal) or DATA_W/4 (hex) digits
//
// Ports:
//   system_clock  in   1             clock, rising edge
//   cpu_rst       in   1             synchronous active-high reset
//   start         in   1             conversion request
//   value_in      in   DATA_W        binary value to format
//   mode_in       in   1             0 = DECIMAL, 1 = HEXADECIMAL
//   busy          out  1             FSM is not in IDLE
//   digits_valid  out  1             one-cycle pulse, digits_out/digit_en just updated
//   digits_out    out  4*NUM_DIGITS  nibble i = display digit i (0 = least significant)
//   digit_en      out  NUM_DIGITS    per-digit enable for the scan stage
//   state_dbg     out  fmt_state_e   current FSM state, for observation only
//
// Handshake: start is taken only on a cycle where busy is low; a request seen
// while busy is high (including the DONE cycle) is dropped, not queued. Each
// accepted request produces exactly one digits_valid pulse unless cpu_rst
// intervenes. digits_out/digit_en hold their value between pulses.
module seg_digit_formatter
    import seg_display_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BCD_DIGITS = 5,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    system_clock,
    input  logic                    cpu_rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value_in,
    input  logic                    mode_in,
    output logic                    busy,
    output logic                    digits_valid,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output fmt_state_e              state_dbg
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int OUT_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    fmt_state_e        state, next_state;
    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              load_hex;
    logic [OUT_W-1:0]  result;
    logic [NUM_DIGITS-1:0] result_en;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_hex   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (mode_e'(mode_in) == HEXADECIMAL) begin
                        load_hex   = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // ------------------------------------------------------- double-dabble
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .bcd      (bcd_q[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Adjusted accumulator shifted left with the next binary bit entering at
    // bit 0; the top bit that falls out is always zero within the parameter
    // limits, so the accumulator stays BCD_W bits.
    assign bcd_next = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[DATA_W-1]};

    // The value and mode are consumed at the accepting edge: the mode picks
    // the next state and value_in seeds bin_q (or, for hex, the result
    // directly), so later input changes cannot disturb a running conversion.
    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            bin_q <= value_in;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (state == SHIFT) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------ results
    // The result is computed for the edge that enters DONE, so digits_out and
    // digits_valid both change at the start of the DONE cycle.
    assign result = load_hex ? OUT_W'(value_in) : OUT_W'(bcd_next);

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nonzero;

    always_comb begin
        seen_nonzero = 1'b0;
        result_en    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nonzero = seen_nonzero | (result[4*i +: 4] != 4'd0);
            result_en[i] = seen_nonzero;
        end
        // Digit 0 stays lit so a zero value still shows "0".
        result_en[0] = 1'b1;
    end
`else
    localparam logic [NUM_DIGITS-1:0] DEC_EN_MASK = NUM_DIGITS'((1 << BCD_DIGITS) - 1);
    localparam logic [NUM_DIGITS-1:0] HEX_EN_MASK = NUM_DIGITS'((1 << (DATA_W / 4)) - 1);

    assign result_en = load_hex ? HEX_EN_MASK : DEC_EN_MASK;
`endif

    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            digits_valid <= 1'b0;
            digits_out   <= '0;
            digit_en     <= NUM_DIGITS'(1);
        end else begin
            digits_valid <= (next_state == DONE);
            if (next_state == DONE) begin
                digits_out <= result;
                digit_en   <= result_en;
            end
        end
    end

endmodule

// File: tb/tb_seg_digit_formatter.sv
// Directed bench for seg_digit_formatter (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg_digit_formatter;
    import seg_display_pkg::*;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        system_clock = 1'b0;
    logic        cpu_rst;
    logic        start;
    logic [15:0] value_in;
    logic        mode_in;
    logic        busy;
    logic        digits_valid;
    logic [31:0] digits_out;
    logic [7:0]  digit_en;
    fmt_state_e  state_dbg;

    int n_checks  = 0;
    int n_pass    = 0;
    int valid_cnt = 0;
    int n_req     = 0;
    logic [31:0] exp_q[$];

    seg_digit_formatter dut (
        .system_clock (system_clock),
        .cpu_rst      (cpu_rst),
        .start        (start),
        .value_in     (value_in),
        .mode_in      (mode_in),
        .busy         (busy),
        .digits_valid (digits_valid),
        .digits_out   (digits_out),
        .digit_en     (digit_en),
        .state_dbg    (state_dbg)
    );

    // ------------------------------------------------ clock / watchdog
    always #5 system_clock = ~system_clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ----------------------------------------------------- scoreboard
    always @(negedge system_clock) begin
        if (digits_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() > 0) begin
                check("digits_out", digits_out, exp_q.pop_front());
            end
        end
    end

    // --------------------------------------------------------- driver
    // Issues one request at the current falling edge and follows it to the
    // cycle after DONE, where the next request may be issued.
    task automatic convert(input string tag, input logic [15:0] v, input logic m,
                           input logic [31:0] exp_d, input logic [7:0] exp_en,
                           input int exp_lat);
        int lat;
        value_in = v;
        mode_in  = m;
        start    = 1'b1;
        exp_q.push_back(exp_d);
        n_req++;
        @(negedge system_clock);
        start = 1'b0;
        lat   = 1;
        while (digits_valid !== 1'b1 && lat < 40) begin
            @(negedge system_clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_digit_en"}, 32'(digit_en), 32'(exp_en));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge system_clock);
        check({tag, "_valid_one_cycle"}, 32'(digits_valid), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, digits_out, exp_d);
    endtask

    // ------------------------------------------------------- stimulus
    initial begin
        int lat;
        int vc;

        cpu_rst  = 1'b1;
        start    = 1'b0;
        value_in = '0;
        mode_in  = 1'b0;
        repeat (3) @(negedge system_clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(digits_valid), 32'd0);
        check("rst_digits", digits_out, 32'h0);
        check("rst_en", 32'(digit_en), 32'h01);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        cpu_rst = 1'b0;
        @(negedge system_clock);

        // Basic conversions
        convert("hex_a2df", 16'hA2DF, 1'b1, 32'h0000A2DF, 8'h0F, 1);
        convert("dec_5555", 16'd5555, 1'b0, 32'h00005555, BLANK ? 8'h0F : 8'h1F, 17);
        convert("dec_65535", 16'd65535, 1'b0, 32'h00065535, 8'h1F, 17);
        convert("dec_0", 16'd0, 1'b0, 32'h00000000, BLANK ? 8'h01 : 8'h1F, 17);
        convert("hex_0007", 16'h0007, 1'b1, 32'h00000007, BLANK ? 8'h01 : 8'h0F, 1);
        convert("hex_ffff", 16'hFFFF, 1'b1, 32'h0000FFFF, 8'h0F, 1);
        convert("dec_40960", 16'd40960, 1'b0, 32'h00040960, 8'h1F, 17);

        // Request while busy is dropped; new value mid-conversion has no effect
        value_in = 16'd12345;
        mode_in  = 1'b0;
        start    = 1'b1;
        exp_q.push_back(32'h00012345);
        n_req++;
        vc = valid_cnt;
        @(negedge system_clock);
        start = 1'b0;
        lat   = 1;
        repeat (4) begin
            @(negedge system_clock);
            lat++;
        end
        value_in = 16'd125;
        mode_in  = 1'b1;
        start    = 1'b1;
        @(negedge system_clock);
        lat++;
        start = 1'b0;
        while (digits_valid !== 1'b1 && lat < 40) begin
            @(negedge system_clock);
            lat++;
        end
        check("busy_start_latency", 32'(lat), 32'd17);
        check("busy_start_en", 32'(digit_en), 32'h1F);
        @(negedge system_clock);
        check("busy_start_one_pulse", 32'(valid_cnt - vc), 32'd1);
        convert("dec_125", 16'd125, 1'b0, 32'h00000125, BLANK ? 8'h07 : 8'h1F, 17);

        // Reset in the middle of a decimal conversion
        value_in = 16'd54321;
        mode_in  = 1'b0;
        start    = 1'b1;
        @(negedge system_clock);
        start = 1'b0;
        repeat (7) @(negedge system_clock);
        cpu_rst = 1'b1;
        vc      = valid_cnt;
        @(negedge system_clock);
        cpu_rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_digits", digits_out, 32'h0);
        check("midrst_en", 32'(digit_en), 32'h01);
        check("midrst_state", 32'(state_dbg), 32'(IDLE));
        repeat (20) @(negedge system_clock);
        check("midrst_no_valid", 32'(valid_cnt - vc), 32'd0);
        convert("dec_54321", 16'd54321, 1'b0, 32'h00054321, 8'h1F, 17);

        // Back-to-back requests, each on the cycle after DONE
        convert("b2b_hex_1234", 16'h1234, 1'b1, 32'h00001234, 8'h0F, 1);
        convert("b2b_dec_9", 16'd9, 1'b0, 32'h00000009, BLANK ? 8'h01 : 8'h1F, 17);

        // ---------------------------------------------------- report
        repeat (3) @(negedge system_clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("valid_pulse_count", 32'(valid_cnt), 32'(n_req));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
